// File: rtl/fft_io_pkg.sv
// Shared types and helpers for the FFT sample I/O buffer.
// Latency: n/a (package only).
// Backpressure: n/a.
package fft_io_pkg;

    // Buffer phases: collecting input samples, presenting them to the core,
    // streaming the core's results out.
    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    // Reverse the low 'width' bits of val (width <= 32); upper bits return 0.
    function automatic logic [31:0] bitrev(input logic [31:0] val, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r[i] = val[width-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_io_buffer_streamer.sv
// Output streamer: walks the result slots in natural order onto a valid/ready port.
// Latency: start_i at edge t gives out_valid_o with index 0 in cycle t+1; 1 word/cycle.
// Backpressure: out_ready_i low freezes counter and every out_* register.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start_i                begin a new stream (slot data must be word 0 this cycle)
//   slot_re_i, slot_im_i   data of slot rd_idx_o, supplied by the parent
//   rd_idx_o               slot the streamer will present next
//   out_ready_i/out_*_o    downstream stream port
//   done_o                 pulse on the handshake of the final index
module fft_io_streamer
    import fft_io_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 32,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [W-1:0]  slot_re_i,
    input  logic [W-1:0]  slot_im_i,
    output logic [AW-1:0] rd_idx_o,
    input  logic          out_ready_i,
    output logic          out_valid_o,
    output logic [W-1:0]  out_real_o,
    output logic [W-1:0]  out_imag_o,
    output logic [AW-1:0] out_idx_o,
    output logic          out_last_o,
    output logic          done_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    logic [AW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic [W-1:0]  re_q, re_d;
    logic [W-1:0]  im_q, im_d;
    logic          hs;

    assign hs     = valid_q & out_ready_i;
    assign done_o = hs & last_q;

    // Slot to load into the output registers on this edge: word 0 on start,
    // otherwise the successor of the word currently being presented.
    assign rd_idx_o = start_i ? '0 : cnt_q + AW'(1);

    always_comb begin
        cnt_d   = cnt_q;
        valid_d = valid_q;
        last_d  = last_q;
        re_d    = re_q;
        im_d    = im_q;
        if (start_i) begin
            cnt_d   = '0;
            valid_d = 1'b1;
            last_d  = 1'b0;
            re_d    = slot_re_i;
            im_d    = slot_im_i;
        end else if (hs) begin
            cnt_d   = cnt_q + AW'(1);
            valid_d = ~last_q;
            last_d  = ~last_q & (cnt_q + AW'(1) == LAST_IDX);
            re_d    = slot_re_i;
            im_d    = slot_im_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_real_o  = re_q;
    assign out_imag_o  = im_q;
    assign out_idx_o   = cnt_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/fft_io_buffer.sv
// FFT sample buffer: loads N samples, exposes them in parallel, captures N results, streams them out.
// Latency: sample visible on mem_out_* after its accept edge; start_out at t -> index 0 valid at t+1.
// Backpressure: in_ready low outside LOAD; out_ready low holds all out_* stable.
//
// Build option: define FFT_IO_BITREV_EN to store input samples at bit-reversed
// slots (decimation-in-time order for the core); otherwise natural order.
// Result capture and output order are natural in both builds.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready/in_*       input sample stream
//   mem_out_real/imag            all N stored words, slot k at [W*k +: W]
//   load_done                    one-cycle pulse, first HOLD cycle
//   start_out, res_in_real/imag  capture strobe and core results (natural order)
//   out_valid/out_ready/out_*    output stream, out_idx = frequency index
//   busy                         high in HOLD and STREAM
module fft_io_buffer
    import fft_io_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 32,
    localparam int AW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_real,
    input  logic [W-1:0]   in_imag,
    output logic [W*N-1:0] mem_out_real,
    output logic [W*N-1:0] mem_out_imag,
    output logic           load_done,
    input  logic           start_out,
    input  logic [W*N-1:0] res_in_real,
    input  logic [W*N-1:0] res_in_imag,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_real,
    output logic [W-1:0]   out_imag,
    output logic [AW-1:0]  out_idx,
    output logic           out_last,
    output logic           busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          load_done_q, load_done_d;
    logic [W-1:0]  mem_re_q [N];
    logic [W-1:0]  mem_im_q [N];

    logic          in_hs;
    logic          capture;
    logic [AW-1:0] wr_slot;
    logic [AW-1:0] rd_idx;
    logic [W-1:0]  slot_re;
    logic [W-1:0]  slot_im;
    logic          str_done;

    assign in_ready = (state_q == ST_LOAD) & ~rst;
    assign in_hs    = in_valid & in_ready;
    assign capture  = (state_q == ST_HOLD) & start_out;
    assign busy     = (state_q != ST_LOAD);
    assign load_done = load_done_q;

`ifdef FFT_IO_BITREV_EN
    assign wr_slot = AW'(bitrev(32'(wr_ptr_q), AW));
`else
    assign wr_slot = wr_ptr_q;
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        load_done_d = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (in_hs) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (wr_ptr_q == LAST_IDX) begin
                        state_d     = ST_HOLD;
                        wr_ptr_d    = '0;
                        load_done_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (start_out) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (str_done) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            wr_ptr_q    <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            load_done_q <= load_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                mem_re_q[k] <= '0;
                mem_im_q[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < N; k++) begin
                mem_re_q[k] <= res_in_real[W*k +: W];
                mem_im_q[k] <= res_in_imag[W*k +: W];
            end
        end else if (in_hs) begin
            mem_re_q[wr_slot] <= in_real;
            mem_im_q[wr_slot] <= in_imag;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_flat
        assign mem_out_real[W*k +: W] = mem_re_q[k];
        assign mem_out_imag[W*k +: W] = mem_im_q[k];
    end

    // On the capture edge the memory still holds the input samples, so word 0
    // for the first output register comes straight from the result bus.
    assign slot_re = capture ? res_in_real[W-1:0] : mem_re_q[rd_idx];
    assign slot_im = capture ? res_in_imag[W-1:0] : mem_im_q[rd_idx];

    fft_io_streamer #(
        .N (N),
        .W (W)
    ) u_streamer (
        .clk         (clk),
        .rst         (rst),
        .start_i     (capture),
        .slot_re_i   (slot_re),
        .slot_im_i   (slot_im),
        .rd_idx_o    (rd_idx),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_real_o  (out_real),
        .out_imag_o  (out_imag),
        .out_idx_o   (out_idx),
        .out_last_o  (out_last),
        .done_o      (str_done)
    );

endmodule

// File: tb/tb_fft_io_buffer.sv
module tb_fft_io_buffer;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int AW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_real;
    logic [W-1:0]   in_imag;
    logic [W*N-1:0] mem_out_real;
    logic [W*N-1:0] mem_out_imag;
    logic           load_done;
    logic           start_out;
    logic [W*N-1:0] res_in_real;
    logic [W*N-1:0] res_in_imag;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_real;
    logic [W-1:0]   out_imag;
    logic [AW-1:0]  out_idx;
    logic           out_last;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    fft_io_buffer #(.N(N), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_real      (in_real),
        .in_imag      (in_imag),
        .mem_out_real (mem_out_real),
        .mem_out_imag (mem_out_imag),
        .load_done    (load_done),
        .start_out    (start_out),
        .res_in_real  (res_in_real),
        .res_in_imag  (res_in_imag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_real     (out_real),
        .out_imag     (out_imag),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Slot that input sample number p lands in.
    function automatic int wa(input int p);
`ifdef FFT_IO_BITREV_EN
        int r;
        r = 0;
        for (int i = 0; i < AW; i++) begin
            if (((p >> i) & 1) != 0) r = r | (1 << (AW - 1 - i));
        end
        return r;
`else
        return p;
`endif
    endfunction

    // ---------------- behavioural model ----------------
    // phase: 0 collecting samples, 1 waiting for results, 2 emitting results
    int          m_phase;
    int          m_nload;
    int          m_oidx;
    bit          m_done;
    bit          m_in_rst;
    logic [W-1:0] m_re [N];
    logic [W-1:0] m_im [N];

    always @(posedge clk) begin
        if (rst) begin
            m_phase  = 0;
            m_nload  = 0;
            m_oidx   = 0;
            m_done   = 1'b0;
            m_in_rst = 1'b1;
            for (int k = 0; k < N; k++) begin
                m_re[k] = '0;
                m_im[k] = '0;
            end
        end else begin
            m_in_rst = 1'b0;
            m_done   = 1'b0;
            if (m_phase == 0) begin
                if (in_valid) begin
                    m_re[wa(m_nload)] = in_real;
                    m_im[wa(m_nload)] = in_imag;
                    m_nload++;
                    if (m_nload == N) begin
                        m_phase = 1;
                        m_nload = 0;
                        m_done  = 1'b1;
                    end
                end
            end else if (m_phase == 1) begin
                if (start_out) begin
                    for (int k = 0; k < N; k++) begin
                        m_re[k] = res_in_real[W*k +: W];
                        m_im[k] = res_in_imag[W*k +: W];
                    end
                    m_phase = 2;
                    m_oidx  = 0;
                end
            end else begin
                if (out_ready) begin
                    if (m_oidx == N - 1) m_phase = 0;
                    else                 m_oidx++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            logic [W*N-1:0] exp_re;
            logic [W*N-1:0] exp_im;
            for (int k = 0; k < N; k++) begin
                exp_re[W*k +: W] = m_re[k];
                exp_im[W*k +: W] = m_im[k];
            end
            chk("in_ready",  {63'd0, in_ready},  {63'd0, (m_phase == 0) && !rst});
            chk("busy",      {63'd0, busy},      {63'd0, m_phase != 0});
            chk("load_done", {63'd0, load_done}, {63'd0, m_done});
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_phase == 2});
            chk("mem_out_real", mem_out_real, exp_re);
            chk("mem_out_imag", mem_out_imag, exp_im);
            if (m_phase == 2) begin
                chk("out_idx",  {62'd0, out_idx},  64'(m_oidx));
                chk("out_real", {48'd0, out_real}, {48'd0, m_re[m_oidx]});
                chk("out_imag", {48'd0, out_imag}, {48'd0, m_im[m_oidx]});
                chk("out_last", {63'd0, out_last}, {63'd0, m_oidx == N - 1});
            end
            if (m_in_rst) begin
                chk("rst_out_idx",  {62'd0, out_idx},  64'd0);
                chk("rst_out_real", {48'd0, out_real}, 64'd0);
                chk("rst_out_imag", {48'd0, out_imag}, 64'd0);
                chk("rst_out_last", {63'd0, out_last}, 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_results(input int base);
        for (int k = 0; k < N; k++) begin
            res_in_real[W*k +: W] = W'(base + k);
            res_in_imag[W*k +: W] = W'(base + 10 + k);
        end
    endtask

    logic [W*N-1:0] lit_slots;
    int             guard;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0;
        start_out = 1'b0; out_ready = 1'b0;
        res_in_real = '0; res_in_imag = '0;
        tick;
        chk_en = 1'b1;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
        chk("reset_mem", mem_out_real, 64'd0);
        tick;
        rst = 1'b0;

        // Natural (or bit-reversed) load of 1..4
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_real = W'(i + 1);
            in_imag = W'(i + 1);
            tick;
        end
`ifdef FFT_IO_BITREV_EN
        lit_slots = {16'd4, 16'd2, 16'd3, 16'd1};
`else
        lit_slots = {16'd4, 16'd3, 16'd2, 16'd1};
`endif
        chk("lit_load_done", {63'd0, load_done}, 64'd1);
        chk("lit_in_ready_hold", {63'd0, in_ready}, 64'd0);
        chk("lit_slots_re", mem_out_real, lit_slots);
        chk("lit_slots_im", mem_out_imag, lit_slots);

        // in_valid during HOLD is ignored
        in_real = 16'd99; in_imag = 16'd99;
        tick;
        chk("lit_load_done_gone", {63'd0, load_done}, 64'd0);
        tick;
        chk("lit_hold_no_write", mem_out_real, lit_slots);

        // Capture results 10..13, stream with backpressure at index 1
        set_results(10);
        out_ready = 1'b1;
        start_out = 1'b1;
        tick;
        start_out = 1'b0;
        chk("lit_first_valid", {63'd0, out_valid}, 64'd1);
        chk("lit_first_idx", {62'd0, out_idx}, 64'd0);
        chk("lit_first_real", {48'd0, out_real}, 64'd10);
        tick;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick;
        chk("lit_bp_idx", {62'd0, out_idx}, 64'd1);
        chk("lit_bp_real", {48'd0, out_real}, 64'd11);
        out_ready = 1'b1;
        start_out = 1'b1;              // ignored while streaming
        tick;
        start_out = 1'b0;
        tick;
        chk("lit_last_idx", {62'd0, out_idx}, 64'd3);
        chk("lit_last_flag", {63'd0, out_last}, 64'd1);
        in_valid = 1'b0;
        tick;
        chk("lit_back_to_load", {63'd0, in_ready}, 64'd1);
        chk("lit_stream_end", {63'd0, out_valid}, 64'd0);

        // start_out during LOAD is ignored
        start_out = 1'b1;
        tick;
        start_out = 1'b0;
        chk("lit_ignored_start", {63'd0, busy}, 64'd0);

        // Partial load then reset
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_real = W'(5 + i);
            in_imag = W'(5 + i);
            tick;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("lit_rst_mem", mem_out_real, 64'd0);
        chk("lit_rst_done", {63'd0, load_done}, 64'd0);

        // Full reload 7..10 required
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_real = W'(7 + i);
            in_imag = W'(7 + i);
            tick;
            if (i == N - 2) chk("lit_no_early_done", {63'd0, load_done}, 64'd0);
        end
        in_valid = 1'b0;
        chk("lit_reload_done", {63'd0, load_done}, 64'd1);

        // Stream results 30..33 under an irregular ready pattern
        tick;
        set_results(30);
        start_out = 1'b1;
        tick;
        start_out = 1'b0;
        guard = 0;
        while (!in_ready && guard < 40) begin
            out_ready = (guard % 3) != 1;
            tick;
            guard++;
        end
        chk("stream_completes", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
